// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: collects BCD digits from a keypad scanner into an entry
// that is committed, edited, cancelled or timed out.
module keypad_entry_ctrl #(
  parameter int NDIG    = 4,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_vld,
  input  logic [3:0]        key_code,
  output logic [4*NDIG-1:0] entry_val,
  output logic [2:0]        digit_cnt,
  output logic              entry_done,
  output logic              entry_abort,
  output logic              busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, COMMIT = 2'd2} state_t;
  state_t            state_q, state_d;
  logic [4*NDIG-1:0] val_q, val_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              done_q, done_d, abort_q, abort_d, busy_q, busy_d, is_dig;
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    tmr_d   = '0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    is_dig  = key_vld && key_code <= 4'd9;
    case (state_q)
      IDLE: if (is_dig) begin
        val_d   = (4*NDIG)'(key_code);
        cnt_d   = 3'd1;
        state_d = ENTRY;
      end
      ENTRY: begin
        tmr_d = key_vld ? '0 : tmr_q + 1'b1;
        if (key_vld) begin
          case (key_code)
            4'hA: begin
              state_d = COMMIT;
              done_d  = 1'b1;
            end
            4'hB: begin
              val_d   = val_q >> 4;
              cnt_d   = cnt_q - 3'd1;
              state_d = (cnt_q == 3'd1) ? IDLE : ENTRY;
            end
            4'hC, 4'hD: begin
              val_d   = '0;
              cnt_d   = '0;
              abort_d = key_code == 4'hD;
              state_d = IDLE;
            end
            4'hE, 4'hF: ;
            default: if (cnt_q < 3'(NDIG)) begin
              val_d = (val_q << 4) | (4*NDIG)'(key_code);
              cnt_d = cnt_q + 3'd1;
            end
          endcase
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          // Idle expiry behaves exactly like a cancel key.
          val_d   = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == ENTRY || state_d == COMMIT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end
  assign entry_val   = val_q;
  assign digit_cnt   = cnt_q;
  assign entry_done  = done_q;
  assign entry_abort = abort_q;
  assign busy        = busy_q;
endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4: maximum number of BCD digits in one entry (legal range 1..7).
REQ-002 SHALL have parameter TIMEOUT, default 50_000_000: idle clock cycles in ENTRY before auto-abort.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key_vld  input  1  one-cycle pulse from the keypad scanner marking one new key press.
REQ-006 SHALL have port key_code  input  4  key value, meaningful only while key_vld=1.
REQ-007 SHALL have port entry_val  output  4*NDIG  BCD digits; the most recent digit occupies bits [3:0].
REQ-008 SHALL have port digit_cnt  output  3  number of digits currently held (0..NDIG).
REQ-009 SHALL have port entry_done  output  1  one-cycle pulse: entry committed.
REQ-010 SHALL have port entry_abort  output  1  one-cycle pulse: entry cancelled or timed out.
REQ-011 SHALL have port busy  output  1  high while in ENTRY or COMMIT.

Function
REQ-012 SHALL decode key_code as follows: 0x0-0x9 digit; 0xA enter; 0xB backspace; 0xC clear; 0xD cancel; 0xE and 0xF ignored.
REQ-013 SHALL implement three states, IDLE, ENTRY and COMMIT; any unused encoding SHALL return to IDLE on the next clock.
REQ-014 SHALL, in IDLE on a digit key, set entry_val to that digit with all upper nibbles zero, set digit_cnt=1, and enter ENTRY.
REQ-015 SHALL, in IDLE, ignore every non-digit key, including enter with no digits held.
REQ-016 SHALL, in ENTRY on a digit key with digit_cnt<NDIG, shift entry_val left by 4 bits, insert the digit at [3:0], and increment digit_cnt.
REQ-017 SHALL, in ENTRY on a digit key with digit_cnt==NDIG, drop the digit, leaving entry_val and digit_cnt unchanged (no wrap, no overflow).
REQ-018 SHALL, in ENTRY on backspace, shift entry_val right by 4 bits with a zero top nibble and decrement digit_cnt; if the result is digit_cnt=0, go to IDLE with no pulse.
REQ-019 SHALL, in ENTRY on clear, zero entry_val and digit_cnt and go to IDLE with no pulse.
REQ-020 SHALL, in ENTRY on cancel, zero entry_val and digit_cnt, pulse entry_abort for one cycle, and go to IDLE.
REQ-021 SHALL, in ENTRY on enter, go to COMMIT.
REQ-022 SHALL, in COMMIT, hold entry_done=1 for exactly that one cycle and go to IDLE on the next cycle.
REQ-023 SHALL, on leaving COMMIT, clear digit_cnt to 0 while entry_val keeps the committed value until the next digit starts a new entry (REQ-014).
REQ-024 SHALL drop any key_vld that arrives in COMMIT, with no effect.
REQ-025 SHALL, in ENTRY, count cycles since the last key_vld; any key_vld resets the count, including ignored keys.
REQ-026 SHALL, when the count reaches TIMEOUT-1 with no key_vld, act as cancel (REQ-020).
REQ-027 SHALL let a key take priority over the timeout when key_vld and the timeout coincide: process the key and reset the count.
REQ-028 SHALL make the effect of a key_vld pulse at edge n visible on the outputs after edge n+1 (one-cycle latency); entry_done and entry_abort SHALL be registered.
REQ-029 SHALL not double-count a key: each key_vld pulse is exactly one event; level-held key_vld is the scanner's responsibility.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force state=IDLE, entry_val=0, digit_cnt=0, entry_done=0, entry_abort=0, busy=0, and timeout count=0, including mid-entry.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-032 SHALL cover: keys 1,2,3,A with NDIG=4 -> entry_val=0x0123, one entry_done pulse, then digit_cnt=0 and busy=0.
REQ-033 SHALL cover: keys 9,8,7,6,5,A -> the 5 is dropped, entry_val=0x9876, digit_cnt=4 before commit.
REQ-034 SHALL cover: keys 4,5,B,B,A -> entry_val=0 after the second B, state IDLE, the A is ignored, no entry_done.
REQ-035 SHALL cover: key 7 then no keys for TIMEOUT cycles (TIMEOUT=16 in sim) -> entry_abort pulse, entry_val=0, busy=0; a key arriving on the expiry cycle -> no abort.
REQ-036 SHALL cover: keys 1,2,D -> entry_abort pulse, entry_val=0; keys 3,4 then rst_n low mid-entry -> all outputs 0 immediately, without waiting for a clock.
REQ-037 SHALL cover: a key_vld during COMMIT, and key_code E/F in all states -> no state or output change.
